// File: rtl/calc1_pkg.sv
// Shared codes for the calc1 request port: command codes, response codes and FSM states.
package calc1_pkg;

    localparam logic [3:0] CMD_NOP = 4'd0;
    localparam logic [3:0] CMD_ADD = 4'd1;
    localparam logic [3:0] CMD_SUB = 4'd2;
    localparam logic [3:0] CMD_SHL = 4'd5;
    localparam logic [3:0] CMD_SHR = 4'd6;

    localparam logic [1:0] RSP_NONE = 2'd0;
    localparam logic [1:0] RSP_OK   = 2'd1;
    localparam logic [1:0] RSP_OVF  = 2'd2;
    localparam logic [1:0] RSP_INV  = 2'd3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OPND2 = 2'd1,
        EXEC  = 2'd2,
        RESP  = 2'd3
    } state_t;

endpackage

// File: rtl/calc1_alu.sv
// Combinational calc1 ALU: add/sub with overflow detection, optional logical shifts.
// Shifts are only built when CALC1_SHIFT_EN is defined; otherwise cmds 5/6 report invalid.
module calc1_alu
    import calc1_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [3:0]        cmd,
    input  logic [DATA_W-1:0] op1,
    input  logic [DATA_W-1:0] op2,
    output logic [1:0]        resp,
    output logic [DATA_W-1:0] result
);

    logic [DATA_W:0] sum;

    assign sum = {1'b0, op1} + {1'b0, op2};

    always_comb begin
        resp   = RSP_INV;
        result = '0;
        case (cmd)
            CMD_ADD: begin
                if (sum[DATA_W]) begin
                    resp = RSP_OVF;
                end else begin
                    resp   = RSP_OK;
                    result = sum[DATA_W-1:0];
                end
            end
            CMD_SUB: begin
                // Unsigned underflow is reported rather than wrapped
                if (op2 > op1) begin
                    resp = RSP_OVF;
                end else begin
                    resp   = RSP_OK;
                    result = op1 - op2;
                end
            end
`ifdef CALC1_SHIFT_EN
            CMD_SHL: begin
                resp   = RSP_OK;
                result = op1 << op2[4:0];
            end
            CMD_SHR: begin
                resp   = RSP_OK;
                result = op1 >> op2[4:0];
            end
`endif
            default: ;
        endcase
    end

endmodule

// File: rtl/calc1_req_responder.sv
// calc1 request responder: two-cycle request capture, fixed-latency response via calc1_alu.
// Optional shift commands are enabled with the CALC1_SHIFT_EN macro.
module calc1_req_responder
    import calc1_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int RESP_LAT = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [3:0]        cmd_in,
    input  logic [DATA_W-1:0] data_in,
    output logic [1:0]        resp_out,
    output logic [DATA_W-1:0] data_out,
    output logic              busy
);

    localparam logic [3:0] LAT_LOAD = 4'(RESP_LAT - 1);

    state_t            state;
    logic [3:0]        cmd;
    logic [DATA_W-1:0] op1;
    logic [DATA_W-1:0] op2;
    logic [3:0]        cnt;
    logic [DATA_W-1:0] alu_op2;
    logic [1:0]        alu_resp;
    logic [DATA_W-1:0] alu_result;

    // With a latency of 1 the result is taken straight out of OPND2, before op2 is registered
    assign alu_op2 = (state == OPND2) ? data_in : op2;
    assign busy    = (state != IDLE);

    calc1_alu #(
        .DATA_W (DATA_W)
    ) u_alu (
        .cmd    (cmd),
        .op1    (op1),
        .op2    (alu_op2),
        .resp   (alu_resp),
        .result (alu_result)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            resp_out <= RSP_NONE;
            data_out <= '0;
            cnt      <= '0;
        end else begin
            resp_out <= RSP_NONE;
            case (state)
                IDLE: begin
                    if (cmd_in != CMD_NOP) begin
                        state <= OPND2;
                    end
                end
                OPND2: begin
                    cnt <= LAT_LOAD;
                    if (RESP_LAT == 1) begin
                        state    <= RESP;
                        resp_out <= alu_resp;
                        data_out <= alu_result;
                    end else begin
                        state <= EXEC;
                    end
                end
                EXEC: begin
                    cnt <= cnt - 4'd1;
                    // Counter reaching zero on this edge: response becomes visible next cycle
                    if (cnt == 4'd1) begin
                        state    <= RESP;
                        resp_out <= alu_resp;
                        data_out <= alu_result;
                    end
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (state == IDLE && cmd_in != CMD_NOP) begin
            cmd <= cmd_in;
            op1 <= data_in;
        end
        if (state == OPND2) begin
            op2 <= data_in;
        end
    end

endmodule
